// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg: shared FSM states, CSR addresses, mstatus fields and interrupt codes
package trap_sequencer_pkg;
    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_TVAL,
        W_STATUS,
        M_STATUS,
        REDIRECT
    } trap_state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    localparam int IRQ_MEI = 11;
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [5:0] CODE_ILLEGAL = 6'd2;
endpackage

// File: rtl/trap_sequencer_irq_select.sv
// trap_sequencer_irq_select: fixed-priority pick of pending+enabled machine interrupts
// Ports:
//   pend  in   XLEN    mip & mie
//   hit   out  1       at least one of MEI/MSI/MTI pending and enabled
//   code  out  CODE_W  winning code, MEI > MSI > MTI
module trap_sequencer_irq_select
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CODE_W = 6
) (
    input  logic [XLEN-1:0]   pend,
    output logic              hit,
    output logic [CODE_W-1:0] code
);
    localparam logic [XLEN-1:0] IRQ_MASK = (XLEN'(1) << IRQ_MEI) | (XLEN'(1) << IRQ_MSI) | (XLEN'(1) << IRQ_MTI);

    always_comb begin
        hit  = |(pend & IRQ_MASK);
        code = pend[IRQ_MEI] ? CODE_W'(IRQ_MEI) : pend[IRQ_MSI] ? CODE_W'(IRQ_MSI) : CODE_W'(IRQ_MTI);
    end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: multi-cycle trap/MRET sequencer driving the CSR write port and fetch redirect
// Ports:
//   clk, rst                       clock, async active-high reset
//   cm_valid/cm_ready              commit handshake (ready only in IDLE)
//   cm_pc, cm_exc, cm_exc_code,    committing instruction and its exception info
//   cm_tval, cm_mret
//   priv_mode                      current privilege (0=U, 3=M)
//   mstatus/mip/mie/mtvec/mepc     current CSR values
//   csr_we/csr_addr/csr_wdata      single CSR write port, one write per state
//   priv_we/priv_next              privilege update
//   redirect_valid/redirect_pc     one-cycle flush + jump
//   busy                           high outside IDLE
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CODE_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cm_valid,
    output logic              cm_ready,
    input  logic [XLEN-1:0]   cm_pc,
    input  logic              cm_exc,
    input  logic [CODE_W-1:0] cm_exc_code,
    input  logic [XLEN-1:0]   cm_tval,
    input  logic              cm_mret,
    input  logic [1:0]        priv_mode,
    input  logic [XLEN-1:0]   mstatus,
    input  logic [XLEN-1:0]   mip,
    input  logic [XLEN-1:0]   mie,
    input  logic [XLEN-1:0]   mtvec,
    input  logic [XLEN-1:0]   mepc,
    output logic              csr_we,
    output logic [11:0]       csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              priv_we,
    output logic [1:0]        priv_next,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              busy
);
    trap_state_t       state, state_nx;
    logic              irq_hit, take_irq, take_trap, accept;
    logic [CODE_W-1:0] irq_code, code_q;
    logic [XLEN-1:0]   epc_q, tval_q, mtvec_q;
    logic              irq_q, mret_q;
    logic [1:0]        priv_q;
    logic [XLEN-1:0]   base, target, cause, ms_trap, ms_mret;

    trap_sequencer_irq_select #(.XLEN(XLEN), .CODE_W(CODE_W)) u_irq (
        .pend (mip & mie),
        .hit  (irq_hit),
        .code (irq_code)
    );

    assign cm_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = cm_valid && cm_ready;
    assign take_irq  = irq_hit && (priv_mode == PRIV_U || mstatus[MS_MIE]);
    // MRET from U-mode is illegal and joins the trap flow
    assign take_trap = take_irq || cm_exc || (cm_mret && priv_mode == PRIV_U);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            epc_q   <= '0;
            tval_q  <= '0;
            mtvec_q <= '0;
            code_q  <= '0;
            irq_q   <= 1'b0;
            mret_q  <= 1'b0;
            priv_q  <= PRIV_U;
        end else begin
            state <= state_nx;
            if (accept) begin
                epc_q   <= {cm_pc[XLEN-1:2], 2'b00};
                code_q  <= take_irq ? irq_code : cm_exc ? cm_exc_code : CODE_W'(CODE_ILLEGAL);
                tval_q  <= (take_irq || !cm_exc) ? '0 : cm_tval;
                irq_q   <= take_irq;
                mret_q  <= !take_trap;
                priv_q  <= priv_mode;
                mtvec_q <= mtvec;
            end
        end
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:     state_nx = !accept ? IDLE : take_trap ? W_EPC : cm_mret ? M_STATUS : IDLE;
            W_EPC:    state_nx = W_CAUSE;
            W_CAUSE:  state_nx = W_TVAL;
            W_TVAL:   state_nx = W_STATUS;
            W_STATUS: state_nx = REDIRECT;
            M_STATUS: state_nx = REDIRECT;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        base = {mtvec_q[XLEN-1:2], 2'b00};
        // vectored mode only applies to interrupts; the add wraps naturally
        target = (irq_q && mtvec_q[1:0] == 2'b01) ? base + (XLEN'(code_q) << 2) : base;
        cause = XLEN'(code_q);
        cause[XLEN-1] = irq_q;
        ms_trap = mstatus;
        ms_trap[MS_MPIE] = mstatus[MS_MIE];
        ms_trap[MS_MIE] = 1'b0;
        ms_trap[MS_MPP_HI:MS_MPP_LO] = priv_q;
        ms_mret = mstatus;
        ms_mret[MS_MIE] = mstatus[MS_MPIE];
        ms_mret[MS_MPIE] = 1'b1;
        ms_mret[MS_MPP_HI:MS_MPP_LO] = PRIV_U;
        csr_we = state inside {W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS};
        csr_addr = state == W_EPC ? CSR_MEPC :
                   state == W_CAUSE ? CSR_MCAUSE :
                   state == W_TVAL ? CSR_MTVAL :
                   csr_we ? CSR_MSTATUS : 12'h000;
        csr_wdata = state == W_EPC ? epc_q :
                    state == W_CAUSE ? cause :
                    state == W_TVAL ? tval_q :
                    state == W_STATUS ? ms_trap :
                    state == M_STATUS ? ms_mret : '0;
        priv_we = state == W_STATUS || state == M_STATUS;
        priv_next = state == W_STATUS ? PRIV_M : state == M_STATUS ? mstatus[MS_MPP_HI:MS_MPP_LO] : PRIV_U;
        redirect_valid = state == REDIRECT;
        redirect_pc = state != REDIRECT ? '0 : mret_q ? mepc : target;
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed stimulus against a transaction-level model with per-cycle compare
module tb_trap_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cm_valid = 1'b0, cm_exc = 1'b0, cm_mret = 1'b0;
    logic [63:0] cm_pc = '0, cm_tval = '0, mstatus = '0, mip = '0, mie = '0, mtvec = '0, mepc = '0;
    logic [5:0]  cm_exc_code = '0;
    logic [1:0]  priv_mode = '0;
    logic        cm_ready, csr_we, priv_we, redirect_valid, busy;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata, redirect_pc;
    logic [1:0]  priv_next;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(64), .CODE_W(6)) dut (
        .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_pc(cm_pc),
        .cm_exc(cm_exc), .cm_exc_code(cm_exc_code), .cm_tval(cm_tval), .cm_mret(cm_mret),
        .priv_mode(priv_mode), .mstatus(mstatus), .mip(mip), .mie(mie), .mtvec(mtvec),
        .mepc(mepc), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .priv_we(priv_we), .priv_next(priv_next), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    typedef struct {
        logic        busy, ready, we;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic        pwe;
        logic [1:0]  pn;
        logic        rv;
        logic [63:0] rpc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_chk = 0, n_pass = 0, cyc = 0, t0 = 0, rd_cyc = -1, n_we = 0, nb = 0;
    logic [63:0] log_epc, log_cause, log_tval, log_status, rd_pc;
    logic [1:0]  log_pn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input logic we, input logic [11:0] addr, input logic [63:0] wd,
                        input logic pwe, input logic [1:0] pn, input logic rv, input logic [63:0] rpc);
        exp_t x;
        x.busy = 1'b1; x.ready = 1'b0; x.we = we; x.addr = addr; x.wdata = wd;
        x.pwe = pwe; x.pn = pn; x.rv = rv; x.rpc = rpc;
        exp_q.push_back(x);
    endtask

    // Transaction model: from the architectural rules, list what each cycle after acceptance must show
    task automatic model(input logic [63:0] pc, input logic exc, input logic [5:0] ecode,
                         input logic [63:0] tval, input logic mret, input logic [1:0] priv,
                         input logic [63:0] ms, input logic [63:0] mp, input logic [63:0] me,
                         input logic [63:0] mt, input logic [63:0] mep);
        logic [63:0] pend, code, tv, base, tgt, st;
        logic        irq;
        pend = mp & me & 64'h888;
        irq  = (pend != 0) && (priv == 2'd0 || ms[3]);
        if (irq) begin
            code = pend[11] ? 64'd11 : pend[3] ? 64'd3 : 64'd7;
            tv   = 64'd0;
        end else if (exc) begin
            code = 64'(ecode);
            tv   = tval;
        end else if (mret && priv == 2'd0) begin
            code = 64'd2;
            tv   = 64'd0;
        end else begin
            if (mret) begin
                st = (ms & ~64'h1888) | (64'(ms[7]) << 3) | 64'h80;
                push(1'b1, 12'h300, st, 1'b1, ms[12:11], 1'b0, 64'd0);
                push(1'b0, 12'h000, 64'd0, 1'b0, 2'd0, 1'b1, mep);
            end
            return;
        end
        base = mt & ~64'h3;
        tgt  = (irq && mt[1:0] == 2'd1) ? base + 64'd4 * code : base;
        st   = (ms & ~64'h1888) | (64'(ms[3]) << 7) | (64'(priv) << 11);
        push(1'b1, 12'h341, pc & ~64'h3, 1'b0, 2'd0, 1'b0, 64'd0);
        push(1'b1, 12'h342, (64'(irq) << 63) | code, 1'b0, 2'd0, 1'b0, 64'd0);
        push(1'b1, 12'h343, tv, 1'b0, 2'd0, 1'b0, 64'd0);
        push(1'b1, 12'h300, st, 1'b1, 2'd3, 1'b0, 64'd0);
        push(1'b0, 12'h000, 64'd0, 1'b0, 2'd0, 1'b1, tgt);
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else begin
            e.busy = 1'b0; e.ready = 1'b1; e.we = 1'b0; e.addr = '0; e.wdata = '0;
            e.pwe = 1'b0; e.pn = '0; e.rv = 1'b0; e.rpc = '0;
        end
        chk("busy", 64'(busy), 64'(e.busy));
        chk("cm_ready", 64'(cm_ready), 64'(e.ready));
        chk("csr_we", 64'(csr_we), 64'(e.we));
        chk("csr_addr", 64'(csr_addr), 64'(e.addr));
        chk("csr_wdata", csr_wdata, e.wdata);
        chk("priv_we", 64'(priv_we), 64'(e.pwe));
        chk("priv_next", 64'(priv_next), 64'(e.pn));
        chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
        chk("redirect_pc", redirect_pc, e.rpc);
        if (csr_we) begin
            n_we++;
            case (csr_addr)
                12'h341: log_epc = csr_wdata;
                12'h342: log_cause = csr_wdata;
                12'h343: log_tval = csr_wdata;
                12'h300: log_status = csr_wdata;
                default: ;
            endcase
        end
        if (priv_we) log_pn = priv_next;
        if (redirect_valid) begin
            rd_pc  = redirect_pc;
            rd_cyc = cyc;
        end
    end

    task automatic drive(input logic [63:0] pc, input logic exc, input logic [5:0] ecode,
                         input logic [63:0] tval, input logic mret, input logic [1:0] priv,
                         input logic [63:0] ms, input logic [63:0] mp, input logic [63:0] me,
                         input logic [63:0] mt, input logic [63:0] mep);
        @(negedge clk);
        log_epc = 'x; log_cause = 'x; log_tval = 'x; log_status = 'x; log_pn = 'x;
        rd_pc = 'x; rd_cyc = -1; nb = n_we;
        cm_pc = pc; cm_exc = exc; cm_exc_code = ecode; cm_tval = tval; cm_mret = mret;
        priv_mode = priv; mstatus = ms; mip = mp; mie = me; mtvec = mt; mepc = mep;
        cm_valid = 1'b1;
        t0 = cyc;
        model(pc, exc, ecode, tval, mret, priv, ms, mp, me, mt, mep);
    endtask

    task automatic send(input logic [63:0] pc, input logic exc, input logic [5:0] ecode,
                        input logic [63:0] tval, input logic mret, input logic [1:0] priv,
                        input logic [63:0] ms, input logic [63:0] mp, input logic [63:0] me,
                        input logic [63:0] mt, input logic [63:0] mep, input int hold);
        drive(pc, exc, ecode, tval, mret, priv, ms, mp, me, mt, mep);
        repeat (hold) @(negedge clk);
        cm_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("sequence_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ECALL from U
        send(64'h8000_0010, 1'b1, 6'd8, 64'd0, 1'b0, 2'd0, 64'd0, 64'd0, 64'd0, 64'h8000_1000, 64'd0, 1);
        chk("t1_mepc", log_epc, 64'h8000_0010);
        chk("t1_mcause", log_cause, 64'd8);
        chk("t1_mtval", log_tval, 64'd0);
        chk("t1_mpp", log_status & 64'h1800, 64'd0);
        chk("t1_redirect", rd_pc, 64'h8000_1000);
        chk("t1_latency", 64'(rd_cyc - t0), 64'd5);

        // M-mode MEI, vectored
        send(64'h8000_0104, 1'b0, 6'd0, 64'd0, 1'b0, 2'd3, 64'h8, 64'h880, 64'h880, 64'h8000_1001, 64'd0, 1);
        chk("t2_mcause", log_cause, 64'h8000_0000_0000_000B);
        chk("t2_redirect", rd_pc, 64'h8000_102C);

        // same but MIE=0 in M-mode: plain commit
        send(64'h8000_0104, 1'b0, 6'd0, 64'd0, 1'b0, 2'd3, 64'h0, 64'h880, 64'h880, 64'h8000_1001, 64'd0, 1);
        chk("t3_no_write", 64'(n_we - nb), 64'd0);
        chk("t3_no_redirect", 64'(rd_cyc < 0), 64'd1);

        // MRET from M
        send(64'h8000_0300, 1'b0, 6'd0, 64'd0, 1'b1, 2'd3, 64'h80, 64'd0, 64'd0, 64'h8000_1000, 64'h8000_0200, 1);
        chk("t4_mstatus", log_status, 64'h88);
        chk("t4_priv_next", 64'(log_pn), 64'd0);
        chk("t4_redirect", rd_pc, 64'h8000_0200);
        chk("t4_latency", 64'(rd_cyc - t0), 64'd2);

        // exception plus pending MTI: interrupt wins
        send(64'h8000_0400, 1'b1, 6'd2, 64'h1234, 1'b0, 2'd3, 64'h8, 64'h80, 64'h80, 64'h8000_1000, 64'd0, 1);
        chk("t5_mcause", log_cause, 64'h8000_0000_0000_0007);
        chk("t5_mtval", log_tval, 64'd0);
        chk("t5_mepc", log_epc, 64'h8000_0400);

        // MRET from U is illegal instruction
        send(64'h8000_0500, 1'b0, 6'd0, 64'd0, 1'b1, 2'd0, 64'h80, 64'd0, 64'd0, 64'h8000_1000, 64'h8000_0200, 1);
        chk("t6_mcause", log_cause, 64'd2);
        chk("t6_mstatus", log_status, 64'h0);
        chk("t6_redirect", rd_pc, 64'h8000_1000);

        // misaligned pc, exception ignores vectored mode, valid held while busy
        send(64'h8000_0013, 1'b1, 6'd5, 64'hdead, 1'b0, 2'd3, 64'h8, 64'd0, 64'd0, 64'h8000_2001, 64'd0, 4);
        chk("t7_mepc", log_epc, 64'h8000_0010);
        chk("t7_mtval", log_tval, 64'hdead);
        chk("t7_mstatus", log_status, 64'h1880);
        chk("t7_redirect", rd_pc, 64'h8000_2000);
        chk("t7_single_trap", 64'(n_we - nb), 64'd4);

        // vectored target wraps around 2^64
        send(64'h100, 1'b0, 6'd0, 64'd0, 1'b0, 2'd0, 64'd0, 64'h800, 64'h800, 64'hFFFF_FFFF_FFFF_FFF1, 64'd0, 1);
        chk("t8_redirect_wrap", rd_pc, 64'h1C);

        // MSI beats MTI
        send(64'h200, 1'b0, 6'd0, 64'd0, 1'b0, 2'd3, 64'h8, 64'h888, 64'h088, 64'h8000_1001, 64'd0, 1);
        chk("t9_mcause", log_cause, 64'h8000_0000_0000_0003);
        chk("t9_redirect", rd_pc, 64'h8000_100C);

        // reset in the middle of a trap
        drive(64'h8000_0010, 1'b1, 6'd8, 64'd0, 1'b0, 2'd0, 64'd0, 64'd0, 64'd0, 64'h8000_1000, 64'd0);
        @(negedge clk);
        cm_valid = 1'b0;
        @(negedge clk);
        nb = n_we;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t10_no_write", 64'(n_we - nb), 64'd0);
        chk("t10_no_redirect", 64'(rd_cyc < 0), 64'd1);
        chk("t10_ready", 64'(cm_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
